// File: rtl/forwarding_unit_pipelined_if.sv
// Bus between the ID/EX/MEM pipeline registers and the forwarding unit.
// Carries the ID sources, producer info, data paths and the forwarding results.
interface forwarding_unit_pipelined_if #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
);
   logic                        id_valid;
   logic [NUM_SRC*ADDR_W-1:0]   id_src_addr;
   logic                        advance;
   logic [ADDR_W-1:0]           idex_rd;
   logic                        idex_reg_write;
   logic                        idex_mem_read;
   logic [ADDR_W-1:0]           exmem_rd;
   logic                        exmem_reg_write;
   logic [DATA_W-1:0]           exmem_data;
   logic [DATA_W-1:0]           memwb_data;
   logic [NUM_SRC*DATA_W-1:0]   regfile_data;
   logic [NUM_SRC*2-1:0]        fwd_sel;
   logic [NUM_SRC*DATA_W-1:0]   operand;
   logic                        stall;
   logic [CNT_W-1:0]            hazard_count;

   modport master (
      output id_valid, id_src_addr, advance,
      output idex_rd, idex_reg_write, idex_mem_read,
      output exmem_rd, exmem_reg_write, exmem_data,
      output memwb_data, regfile_data,
      input  fwd_sel, operand, stall, hazard_count
   );

   modport slave (
      input  id_valid, id_src_addr, advance,
      input  idex_rd, idex_reg_write, idex_mem_read,
      input  exmem_rd, exmem_reg_write, exmem_data,
      input  memwb_data, regfile_data,
      output fwd_sel, operand, stall, hazard_count
   );
endinterface

// File: rtl/forwarding_unit_pipelined.sv
// Forwarding selects precomputed in ID, registered into EX, plus
// load-use hazard detection with a multi-cycle stall FSM.
module forwarding_unit_pipelined #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_STALL  = 1,
   parameter int ZERO_REG_EN = 1,
   parameter int CNT_W       = 16
) (
   input logic                       clock,
   input logic                       reset_n,
   forwarding_unit_pipelined_if.slave bus
);
   localparam int SC_W = (LOAD_STALL > 2) ? $clog2(LOAD_STALL) : 1;
   localparam logic [SC_W-1:0] SC_LOAD =
      SC_W'(LOAD_STALL > 1 ? LOAD_STALL - 2 : 0);

   typedef enum logic {IDLE, STALL} state_t;

   state_t                state, next_state;
   logic [SC_W-1:0]       cnt, next_cnt;
   logic [NUM_SRC*2-1:0]  sel, next_sel;
   logic [CNT_W-1:0]      count;
   logic [ADDR_W-1:0]     src;
   logic                  hazard;
   logic                  stall_raw;
   logic [NUM_SRC*DATA_W-1:0] ops;

   function automatic logic match(
      input logic [ADDR_W-1:0] a,
      input logic [ADDR_W-1:0] b
   );
      return (a == b) && !(ZERO_REG_EN != 0 && a == '0);
   endfunction

   // nearest producer wins: ID/EX lands in EX/MEM when consumer is in EX
   always_comb begin
      next_sel = '0;
      hazard   = 1'b0;
      src      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = bus.id_src_addr[i*ADDR_W +: ADDR_W];
         if (bus.id_valid) begin
            if (bus.idex_reg_write && match(bus.idex_rd, src))
               next_sel[i*2 +: 2] = 2'b10;
            else if (bus.exmem_reg_write && match(bus.exmem_rd, src))
               next_sel[i*2 +: 2] = 2'b01;
            if (bus.idex_mem_read && bus.idex_reg_write &&
                match(bus.idex_rd, src))
               hazard = 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      stall_raw  = 1'b0;
      case (state)
         IDLE: begin
            if (hazard) begin
               stall_raw = 1'b1;
               if (LOAD_STALL > 1) begin
                  next_state = STALL;
                  next_cnt   = SC_LOAD;
               end
            end
         end
         STALL: begin
            stall_raw = 1'b1;
            if (cnt == '0)
               next_state = IDLE;
            else
               next_cnt = cnt - 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // the bubble inserted during a stall must not forward
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         sel <= '0;
      else if (stall_raw)
         sel <= '0;
      else if (bus.advance)
         sel <= next_sel;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (state == IDLE && hazard && count != '1)
         count <= count + CNT_W'(1);
   end

   always_comb begin
      ops = bus.regfile_data;
      for (int i = 0; i < NUM_SRC; i++) begin
         case (sel[i*2 +: 2])
            2'b10:   ops[i*DATA_W +: DATA_W] = bus.exmem_data;
            2'b01:   ops[i*DATA_W +: DATA_W] = bus.memwb_data;
            default: ;
         endcase
      end
   end

   assign bus.fwd_sel      = sel;
   assign bus.operand      = ops;
   assign bus.stall        = reset_n & stall_raw;
   assign bus.hazard_count = count;
endmodule

// File: doc/forwarding_unit_pipelined.md
Name: forwarding_unit_pipelined

Overview:
- Parametrised successor of the EX-stage forwarding logic.
- Precomputes per-operand forwarding selects one stage early, in ID, against the ID/EX and EX/MEM producers. Registers the selects into EX.
- Drives the EX operand muxes and detects load-use hazards, issuing a multi-cycle stall through a small FSM.
- Sits between the decode stage and the ALU input muxes of the 5-stage pipeline.

Parameters:
- ADDR_W, 5: register-address width.
- DATA_W, 32: operand data width.
- NUM_SRC, 2: number of source operands per instruction.
- LOAD_STALL, 1: stall cycles per load-use hazard; must be at least 1.
- ZERO_REG_EN, 1: when 1, register address 0 never matches.
- CNT_W, 16: width of the hazard statistics counter.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- id_valid, input, 1: the ID stage holds a real instruction.
- id_src_addr, input, NUM_SRC*ADDR_W: ID source register addresses; operand i occupies bits [i*ADDR_W +: ADDR_W].
- advance, input, 1: the pipeline moves ID to EX this cycle; 0 means an external freeze.
- idex_rd, input, ADDR_W: destination register in ID/EX.
- idex_reg_write, input, 1: write-back enable in ID/EX.
- idex_mem_read, input, 1: the ID/EX instruction is a load.
- exmem_rd, input, ADDR_W: destination register in EX/MEM.
- exmem_reg_write, input, 1: write-back enable in EX/MEM.
- exmem_data, input, DATA_W: ALU result in EX/MEM.
- memwb_data, input, DATA_W: write-back value in MEM/WB.
- regfile_data, input, NUM_SRC*DATA_W: register-file read data for the EX instruction.
- fwd_sel, output, NUM_SRC*2: registered per-operand select (00 = register file, 10 = EX/MEM, 01 = MEM/WB).
- operand, output, NUM_SRC*DATA_W: muxed EX operands.
- stall, output, 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- hazard_count, output, CNT_W: number of load-use stalls initiated.

Behaviour:
- Reset: while reset_n is 0, all of the following hold asynchronously and are held until reset_n rises:
  - fwd_sel = 0.
  - stall = 0.
  - hazard_count = 0.
  - FSM in IDLE, stall counter = 0.
  - Reset during STALL aborts the stall immediately.
- Match definition: match(a, b) = (a == b) && !(ZERO_REG_EN && a == 0).
- Next-select for operand i (combinational, priority order):
  - If idex_reg_write && match(idex_rd, src_i), then 10. The producer will be in EX/MEM when the consumer is in EX.
  - Else if exmem_reg_write && match(exmem_rd, src_i), then 01.
  - Else 00.
  - If id_valid is 0, the next-select is 00.
- Priority: the nearest producer wins; EX/MEM beats MEM/WB when both match.
- Load-use hazard: hazard = id_valid && idex_mem_read && idex_reg_write && match(idex_rd, src_i) for any i.
- stall output is combinational: stall = (state == IDLE && hazard) || state == STALL.
- FSM:
  - IDLE, hazard, LOAD_STALL == 1: stay in IDLE.
  - IDLE, hazard, LOAD_STALL > 1: go to STALL and load counter = LOAD_STALL - 2.
  - STALL, counter == 0: go to IDLE.
  - STALL, counter != 0: decrement counter.
  - In the cycle after the final stall cycle, selects are recomputed with the bubble now in ID/EX. The load is then in EX/MEM (select 01) or retired; the register file is write-first, so retired data reads correctly.
- fwd_sel register update, evaluated at each rising edge in this order:
  - If stall is 1, load 00 for every operand, so the bubble uses no forwarding. This applies regardless of advance.
  - Else if advance is 1, load the next-select.
  - Else hold.
- Operand mux (combinational on fwd_sel):
  - 10 selects exmem_data.
  - 01 selects memwb_data.
  - 00 or 11 selects regfile_data.
- hazard_count increments by 1 on each IDLE-to-stall entry (state == IDLE && hazard). It saturates at all-ones.
- Latency:
  - Selects: 1 cycle, ID to EX.
  - Operands: 0 cycles from fwd_sel and the data inputs.
  - stall: 0 cycles from hazard.
- Simultaneous events:
  - Hazard together with advance = 0: stall is still asserted and the counter still runs.
  - A new hazard cannot start while in STALL; it is re-evaluated in IDLE.

Test Plan:
1. Reset release, id_valid = 0 -> fwd_sel = 0, stall = 0, hazard_count = 0, operand = regfile_data.
2. idex_rd = 3, idex_reg_write = 1, src0 = 3, advance = 1 -> next cycle fwd_sel[1:0] = 10 and operand0 = exmem_data = 0xDEADBEEF.
3. idex_rd = 4 and exmem_rd = 4, both writing, src1 = 4 -> fwd_sel[3:2] = 10 (EX/MEM priority). Repeat with idex_reg_write = 0 -> fwd_sel[3:2] = 01, operand1 = memwb_data.
4. src0 = 0 with idex_rd = 0 writing, ZERO_REG_EN = 1 -> fwd_sel = 00, no stall.
5. LOAD_STALL = 3, load idex_rd = 7, src1 = 7 -> stall high for exactly 3 cycles, fwd_sel = 00 during the stall, hazard_count = 1.
6. Same as scenario 5, but pulse reset_n low in the second stall cycle -> stall drops immediately and the FSM is in IDLE. Separately, drive 2^CNT_W hazards -> hazard_count saturates at all-ones.
